// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared constants and helpers for the decode-side interlock/forwarding controller.
// Operand-select encodings and the forwarding priority rule live here.
package hazard_fwd_ctrl_pkg;

   localparam int RN_W = 5;

   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_EXALU  = 2'b01;
   localparam logic [1:0] FWD_MEMALU = 2'b10;
   localparam logic [1:0] FWD_MEMLD  = 2'b11;

   // Youngest producer wins; an EX load cannot forward yet and falls through.
   function automatic logic [1:0] fwd_pick(input logic ex_hit,
                                           input logic ex_m2reg,
                                           input logic mem_hit,
                                           input logic mem_m2reg);
      logic [1:0] sel;
      sel = FWD_RF;
      if (ex_hit && !ex_m2reg) begin
         sel = FWD_EXALU;
      end else if (mem_hit) begin
         sel = mem_m2reg ? FWD_MEMLD : FWD_MEMALU;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_if.sv
// Decode-stage <-> hazard controller bundle: ID instruction fields in,
// interlock/forward controls and the stall counter out.
interface hazard_fwd_ctrl_if #(
   parameter int RN_W  = hazard_fwd_ctrl_pkg::RN_W,
   parameter int CNT_W = 32
);
   logic [RN_W-1:0]  id_rs;
   logic [RN_W-1:0]  id_rt;
   logic [RN_W-1:0]  id_rn;
   logic             id_wreg;
   logic             id_m2reg;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_br_taken;
   logic             ext_hold;

   logic             wpcir;
   logic             id_bubble;
   logic             if_flush;
   logic [1:0]       fwda;
   logic [1:0]       fwdb;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs, id_rt, id_rn, id_wreg, id_m2reg, id_use_rs, id_use_rt,
             id_br_taken, ext_hold,
      input  wpcir, id_bubble, if_flush, fwda, fwdb, stall_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_rn, id_wreg, id_m2reg, id_use_rs, id_use_rt,
             id_br_taken, ext_hold,
      output wpcir, id_bubble, if_flush, fwda, fwdb, stall_cnt
   );
endinterface

// File: rtl/hazard_fwd_ctrl_hzd_match.sv
// Dependency compare of one ID source operand against one downstream stage.
// r0 is hardwired to zero, so a write to it never creates a dependency.
module hazard_fwd_ctrl_hzd_match #(
   parameter int RN_W = 5
) (
   input  logic [RN_W-1:0] src,
   input  logic            src_use,
   input  logic [RN_W-1:0] stage_rn,
   input  logic            stage_wreg,
   output logic            hit
);

   assign hit = src_use & stage_wreg & (stage_rn != '0) & (stage_rn == src);

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Load-use interlock, operand forwarding selects, branch flush and hold freeze
// for the 5-stage core, driven from shadow copies of the EX/MEM destinations.
module hazard_fwd_ctrl #(
   parameter int RN_W  = hazard_fwd_ctrl_pkg::RN_W,
   parameter int CNT_W = 32
) (
   input  logic                clk,
   input  logic                clrn,
   hazard_fwd_ctrl_if.slave    bus
);
   import hazard_fwd_ctrl_pkg::*;

   logic [RN_W-1:0] ex_rn;
   logic            ex_wreg;
   logic            ex_m2reg;
   logic [RN_W-1:0] mem_rn;
   logic            mem_wreg;
   logic            mem_m2reg;

   logic hit_ex_a;
   logic hit_ex_b;
   logic hit_mem_a;
   logic hit_mem_b;
   logic load_use;
   logic stall;

   hazard_fwd_ctrl_hzd_match #(.RN_W(RN_W)) u_match_ex_a (
      .src(bus.id_rs), .src_use(bus.id_use_rs),
      .stage_rn(ex_rn), .stage_wreg(ex_wreg), .hit(hit_ex_a)
   );

   hazard_fwd_ctrl_hzd_match #(.RN_W(RN_W)) u_match_ex_b (
      .src(bus.id_rt), .src_use(bus.id_use_rt),
      .stage_rn(ex_rn), .stage_wreg(ex_wreg), .hit(hit_ex_b)
   );

   hazard_fwd_ctrl_hzd_match #(.RN_W(RN_W)) u_match_mem_a (
      .src(bus.id_rs), .src_use(bus.id_use_rs),
      .stage_rn(mem_rn), .stage_wreg(mem_wreg), .hit(hit_mem_a)
   );

   hazard_fwd_ctrl_hzd_match #(.RN_W(RN_W)) u_match_mem_b (
      .src(bus.id_rt), .src_use(bus.id_use_rt),
      .stage_rn(mem_rn), .stage_wreg(mem_wreg), .hit(hit_mem_b)
   );

   // clrn gating keeps wpcir high and the rest quiet while reset is asserted,
   // regardless of what the decode stage presents.
   always_comb begin
      load_use = clrn & ex_m2reg & (hit_ex_a | hit_ex_b);
      stall    = clrn & (load_use | bus.ext_hold);
   end

   assign bus.wpcir     = ~stall;
   assign bus.id_bubble = load_use & ~bus.ext_hold;
   assign bus.if_flush  = clrn & bus.id_br_taken & ~stall;
   assign bus.fwda      = clrn ? fwd_pick(hit_ex_a, ex_m2reg, hit_mem_a, mem_m2reg) : FWD_RF;
   assign bus.fwdb      = clrn ? fwd_pick(hit_ex_b, ex_m2reg, hit_mem_b, mem_m2reg) : FWD_RF;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         ex_rn     <= '0;
         ex_wreg   <= 1'b0;
         ex_m2reg  <= 1'b0;
         mem_rn    <= '0;
         mem_wreg  <= 1'b0;
         mem_m2reg <= 1'b0;
      end else if (!bus.ext_hold) begin
         mem_rn    <= ex_rn;
         mem_wreg  <= ex_wreg;
         mem_m2reg <= ex_m2reg;
         ex_rn     <= bus.id_bubble ? '0 : bus.id_rn;
         ex_wreg   <= bus.id_wreg  & ~bus.id_bubble;
         ex_m2reg  <= bus.id_m2reg & ~bus.id_bubble;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         bus.stall_cnt <= '0;
      end else if (stall) begin
         bus.stall_cnt <= bus.stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed pipeline scenarios followed
// by random instruction streams, compared against an in-flight pipeline model.
module tb_hazard_fwd_ctrl;

   localparam int RN_W  = 5;
   localparam int CNT_W = 32;

   logic clk  = 1'b0;
   logic clrn = 1'b1;

   always #5 clk = ~clk;

   hazard_fwd_ctrl_if #(.RN_W(RN_W), .CNT_W(CNT_W)) bus ();

   hazard_fwd_ctrl #(.RN_W(RN_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .clrn(clrn),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model: what is in flight downstream of ID (a bubble is an empty slot).
   typedef struct packed {
      logic            w;
      logic [RN_W-1:0] rn;
      logic            ld;
   } slot_t;

   slot_t       ex_s;
   slot_t       mem_s;
   int unsigned m_cnt;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   // Find the youngest in-flight writer of src; a load still in EX cannot supply it.
   task automatic predict(input int src, input bit src_use, output bit ld_wait, output logic [1:0] sel);
      logic [RN_W-1:0] r;
      r       = src[RN_W-1:0];
      ld_wait = 1'b0;
      sel     = 2'd0;
      if (src_use && r != 0) begin
         if (ex_s.w && ex_s.rn == r) begin
            if (ex_s.ld) ld_wait = 1'b1;
            else         sel = 2'd1;
         end else if (mem_s.w && mem_s.rn == r) begin
            sel = mem_s.ld ? 2'd3 : 2'd2;
         end
      end
   endtask

   task automatic step(input int rs, input int rt, input int rn,
                       input bit wr, input bit ld, input bit urs, input bit urt,
                       input bit br, input bit hold);
      logic [1:0] ea;
      logic [1:0] eb;
      bit         la;
      bit         lb;
      bit         lu;
      bit         st;
      slot_t      s;
      bus.id_rs       = rs[RN_W-1:0];
      bus.id_rt       = rt[RN_W-1:0];
      bus.id_rn       = rn[RN_W-1:0];
      bus.id_wreg     = wr;
      bus.id_m2reg    = ld;
      bus.id_use_rs   = urs;
      bus.id_use_rt   = urt;
      bus.id_br_taken = br;
      bus.ext_hold    = hold;
      #1;
      predict(rs, urs, la, ea);
      predict(rt, urt, lb, eb);
      lu = la | lb;
      st = lu | hold;
      check_val("wpcir",     32'(bus.wpcir),     32'(!st));
      check_val("id_bubble", 32'(bus.id_bubble), 32'(lu && !hold));
      check_val("if_flush",  32'(bus.if_flush),  32'(br && !st));
      check_val("stall_cnt", bus.stall_cnt,      m_cnt);
      if (!lu) begin
         check_val("fwda", 32'(bus.fwda), 32'(ea));
         check_val("fwdb", 32'(bus.fwdb), 32'(eb));
      end
      @(posedge clk);
      if (!hold) begin
         mem_s = ex_s;
         s.w   = wr & !lu;
         s.rn  = rn[RN_W-1:0];
         s.ld  = ld & !lu;
         ex_s  = s;
      end
      if (st) m_cnt++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus.ext_hold    = 1'b1;
      bus.id_br_taken = 1'b1;
      clrn            = 1'b0;
      #1;
      ex_s  = '0;
      mem_s = '0;
      m_cnt = 0;
      check_val("rst_wpcir",  32'(bus.wpcir),     32'd1);
      check_val("rst_bubble", 32'(bus.id_bubble), 32'd0);
      check_val("rst_flush",  32'(bus.if_flush),  32'd0);
      check_val("rst_fwda",   32'(bus.fwda),      32'd0);
      check_val("rst_fwdb",   32'(bus.fwdb),      32'd0);
      check_val("rst_cnt",    bus.stall_cnt,      32'd0);
      @(negedge clk);
      clrn = 1'b1;
   endtask

   initial begin
      int unsigned c0;
      bus.id_rs = '0; bus.id_rt = '0; bus.id_rn = '0;
      bus.id_wreg = 1'b0; bus.id_m2reg = 1'b0;
      bus.id_use_rs = 1'b1; bus.id_use_rt = 1'b1;
      bus.id_br_taken = 1'b0; bus.ext_hold = 1'b0;
      ex_s = '0; mem_s = '0; m_cnt = 0;
      do_reset();

      // add r3 ; sub r4,r3,r5 -> EX ALU forward, no stall
      step(1, 2, 3, 1, 0, 1, 1, 0, 0);
      step(3, 5, 4, 1, 0, 1, 1, 0, 0);
      check_val("tp_add_cnt", bus.stall_cnt, 32'd0);

      // ld r7 ; add r8,r7,r7 -> one bubble then load-data forward
      step(1, 2, 7, 1, 1, 1, 1, 0, 0);
      step(7, 7, 8, 1, 0, 1, 1, 0, 0);
      step(7, 7, 8, 1, 0, 1, 1, 0, 0);
      check_val("tp_ld_cnt", bus.stall_cnt, 32'd1);

      // write r0 then read r0
      step(1, 2, 0, 1, 0, 1, 1, 0, 0);
      step(0, 0, 9, 1, 0, 1, 1, 0, 0);

      // taken branch clean, then branch on a just-loaded register
      step(1, 2, 0, 0, 0, 1, 1, 1, 0);
      step(1, 2, 6, 1, 1, 1, 1, 0, 0);
      step(6, 2, 0, 0, 0, 1, 1, 1, 0);
      step(6, 2, 0, 0, 0, 1, 1, 1, 0);

      // hold for three cycles across a load-use
      c0 = bus.stall_cnt;
      step(1, 2, 7, 1, 1, 1, 1, 0, 0);
      step(7, 3, 8, 1, 0, 1, 1, 0, 1);
      step(7, 3, 8, 1, 0, 1, 1, 0, 1);
      step(7, 3, 8, 1, 0, 1, 1, 0, 1);
      step(7, 3, 8, 1, 0, 1, 1, 0, 0);
      step(7, 3, 8, 1, 0, 1, 1, 0, 0);
      check_val("tp_hold_cnt", bus.stall_cnt - c0, 32'd4);

      // reset while EX holds a load; next reader sees nothing in flight
      step(1, 2, 7, 1, 1, 1, 1, 0, 0);
      do_reset();
      step(7, 7, 8, 1, 0, 1, 1, 0, 0);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(99) == 0) begin
            do_reset();
         end else begin
            step($urandom_range(3), $urandom_range(3), $urandom_range(3),
                 $urandom_range(3) != 0, $urandom_range(2) == 0,
                 $urandom_range(3) != 0, $urandom_range(3) != 0,
                 $urandom_range(4) == 0, $urandom_range(6) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
Pipeline interlock and forwarding controller for the 5-stage core, sitting beside the decode stage.
- Keeps its own shadow copies of the EX and MEM destination info: rn, wreg, m2reg.
- Produces operand-forward selects for the decode a/b muxes, the load-use stall, the taken-branch IF/ID flush and a global hold freeze.
- Counts stall cycles for performance monitoring.

Parameters:
RN_W, 5, register-number width
CNT_W, 32, stall counter width

Ports:
clk  in  1  system clock, rising edge
clrn  in  1  reset, asynchronous, active-low
id_rs  in  RN_W  source register a of the instruction in ID
id_rt  in  RN_W  source register b of the instruction in ID
id_rn  in  RN_W  destination register of the instruction in ID (after regrt mux)
id_wreg  in  1  ID instruction writes the register file
id_m2reg  in  1  ID instruction is a load
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_br_taken  in  1  ID branch/jump redirects the PC (pcsource != 0)
ext_hold  in  1  memory not ready; freeze the whole pipeline
wpcir  out  1  write enable for the PC and IF/ID registers
id_bubble  out  1  force ID/EX control fields to zero this cycle
if_flush  out  1  replace the IF/ID instruction with a NOP at the next edge
fwda  out  2  a-operand select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data
fwdb  out  2  b-operand select, same encoding as fwda
stall_cnt  out  CNT_W  number of cycles with wpcir=0

Behaviour:
- Shadow registers: ex_rn, ex_wreg, ex_m2reg, mem_rn, mem_wreg, mem_m2reg.
  - All reset to 0 on clrn low, asynchronously.
- Clock edge with ext_hold=0:
  - MEM shadow <= EX shadow.
  - EX shadow <= ID fields. If id_bubble=1, EX shadow wreg and m2reg <= 0 and rn is don't-care.
- Clock edge with ext_hold=1: no shadow register changes.
- A match requires all of:
  - the stage's wreg=1;
  - the stage rn != 0 (r0 never matches);
  - rn equal to the source register;
  - the corresponding id_use_* = 1.
- fwda priority, first match wins:
  - EX match and ex_m2reg=0 -> 01.
  - MEM match -> 11 if mem_m2reg=1, else 10.
  - Otherwise 00.
- fwdb: identical rule on id_rt and id_use_rt.
- load_use = EX match on rs or rt with ex_m2reg=1. In this case fwda/fwdb are don't-care.
- stall = load_use | ext_hold.
- Combinational outputs:
  - wpcir = ~stall.
  - id_bubble = load_use & ~ext_hold.
  - if_flush = id_br_taken & ~stall. A branch that depends on a load is not evaluated until the stall clears.
- All combinational outputs are 0/00 while clrn=0, except wpcir=1.
- stall_cnt:
  - Reset to 0.
  - Increments by 1 at each edge with stall=1.
  - Wraps at 2^CNT_W-1 -> 0.
- Latency: load-use costs exactly one bubble. On the next cycle the producer sits in MEM and fwd selects 11.
- Simultaneous load_use and id_br_taken: stall wins, if_flush=0. The flush occurs on the following cycle.
- ext_hold mid-load-use: the state is frozen and no bubble is inserted. The load_use stall resumes when the hold is released.
- Reset mid-operation: the shadow registers clear immediately, so no forwarding or stall is possible in the first cycle after release.

Decomposition:
- Shared package constants:
  - FWD_RF=2'b00, FWD_EXALU=2'b01, FWD_MEMALU=2'b10, FWD_MEMLD=2'b11.
  - RN_W.
- One sub-module, hzd_match, is natural: a combinational compare of (src, use, stage rn, stage wreg) giving a hit. It is instantiated 4 times (EX/MEM x rs/rt).

Test Plan:
- add r3 then sub r4,r3,r5 back-to-back -> fwda=01 in the sub's ID cycle; no stall; stall_cnt stays 0.
- ld r7 then add r8,r7,r7 -> cycle 1: wpcir=0, id_bubble=1, fwda=fwdb=don't-care. Cycle 2: wpcir=1, fwda=fwdb=11. stall_cnt=1.
- Write to r0 in EX, then a reader of r0 -> fwda=00, no stall.
- Taken beq with no hazards -> if_flush=1 for one cycle, wpcir=1. Then beq after ld on its operand -> stall cycle with if_flush=0, then if_flush=1 with fwd=11.
- ext_hold=1 for 3 cycles during a load-use -> wpcir=0, id_bubble=0, shadow registers unchanged, stall_cnt +3. After release, one bubble; stall_cnt +1 more.
- clrn pulsed low while EX holds a load -> shadow registers 0 at once; the next reader gets fwda=00, no stall.
